neuron_layer_buffer: RTL and testbench

Double-buffered (ping-pong) activation store between fully-connected layers. The upstream layer streams neuron values in index order through a valid/ready handshake into one bank. Meanwhile the downstream layer reads the other, completed bank as a parallel vector. Adds correct address sizing, bank swapping with backpressure, optional ReLU on write, and a partial-fill flush.

---
 rtl/neuron_layer_pkg.sv | 15 +
 rtl/neuron_bank.sv | 34 +++
 rtl/neuron_layer_buffer.sv | 106 ++++++++++
 tb/tb_neuron_layer_buffer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/neuron_layer_pkg.sv
// Shared types and defaults for the ping-pong activation buffer between
// fully-connected layers.
package neuron_layer_pkg;

    localparam int NEURON_SIZE     = 16;
    localparam int NEURON_LAYER_SZ = 84;

    typedef logic signed [NEURON_SIZE-1:0] neuron_t;

    // Clamp negative fixed-point values to zero; non-negative values pass unchanged.
    function automatic neuron_t relu(input neuron_t v);
        return v[NEURON_SIZE-1] ? neuron_t'(0) : v;
    endfunction

endpackage

// File: rtl/neuron_bank.sv
// One layer's worth of neuron registers: single write port addressed by index,
// every element visible in parallel on the read side.
module neuron_bank #(
    parameter int SIZE     = 16,
    parameter int LAYER_SZ = 84,
    parameter int ADDR_W   = $clog2(LAYER_SZ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_idx,
    input  logic [SIZE-1:0]          wr_data,
    output logic [LAYER_SZ*SIZE-1:0] rd_values
);

    logic [SIZE-1:0] mem [LAYER_SZ];

    // Register array: cleared on reset, one element written per enabled cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAYER_SZ; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Flatten the array so element 0 sits in the least significant slice.
    for (genvar g = 0; g < LAYER_SZ; g++) begin : g_rd
        assign rd_values[g*SIZE +: SIZE] = mem[g];
    end

endmodule

// File: rtl/neuron_layer_buffer.sv
// Double-buffered activation store. The upstream layer fills the write bank
// one value per cycle in index order (valid/ready: a value transfers on a
// clock edge where in_valid and in_ready are both high, in_ready depends only
// on buffer state, never on in_valid). The downstream layer reads the other,
// completed bank in parallel and releases it with consume.
module neuron_layer_buffer
    import neuron_layer_pkg::*;
#(
    parameter  int SIZE     = NEURON_SIZE,
    parameter  int LAYER_SZ = NEURON_LAYER_SZ,
    parameter  int RELU     = 0,
    localparam int ADDR_W   = $clog2(LAYER_SZ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SIZE-1:0]          in_value,
    input  logic                     flush,
    input  logic                     consume,
    output logic                     o_valid,
    output logic [LAYER_SZ*SIZE-1:0] o_values,
    output logic [ADDR_W:0]          o_fill,
    output logic                     o_err
);

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(LAYER_SZ - 1);
    localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W+1)'(1);

    logic [1:0]             full;
    logic [1:0]             full_next;
    logic                   wr_sel;
    logic                   rd_sel;
    logic [ADDR_W:0]        wr_idx;
    logic                   accept;
    logic                   last_accept;
    logic                   do_consume;
    logic [SIZE-1:0]        wr_data;
    logic [1:0]             bank_we;
    logic [LAYER_SZ*SIZE-1:0] bank_values [2];

    assign in_ready    = !full[wr_sel];
    assign o_valid     = full[rd_sel];
    assign o_fill      = wr_idx;
    // A flush in the same cycle wins: the offered value is dropped.
    assign accept      = in_valid && in_ready && !flush;
    assign last_accept = accept && (wr_idx == LAST_IDX);
    assign do_consume  = consume && o_valid;
    assign bank_we     = {accept && wr_sel, accept && !wr_sel};
    assign o_values    = bank_values[rd_sel];

    // Optional ReLU on the write path; the package helper covers the default width.
    if (RELU != 0 && SIZE == NEURON_SIZE) begin : g_relu_pkg
        assign wr_data = relu(in_value);
    end else if (RELU != 0) begin : g_relu_wide
        assign wr_data = in_value[SIZE-1] ? '0 : in_value;
    end else begin : g_relu_off
        assign wr_data = in_value;
    end

    // Full flags: a completed fill and a consume never hit the same bank, so both apply.
    always_comb begin
        full_next = full;
        if (last_accept) full_next[wr_sel] = 1'b1;
        if (do_consume)  full_next[rd_sel] = 1'b0;
    end

    // Control registers: flags, bank selects, fill index and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            full   <= 2'b00;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            wr_idx <= '0;
            o_err  <= 1'b0;
        end else begin
            full <= full_next;
            if (flush) begin
                wr_idx <= '0;
            end else if (last_accept) begin
                wr_idx <= '0;
                wr_sel <= !wr_sel;
            end else if (accept) begin
                wr_idx <= wr_idx + IDX_ONE;
            end
            if (do_consume) rd_sel <= !rd_sel;
            if (consume && !o_valid) o_err <= 1'b1;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        neuron_bank #(
            .SIZE     (SIZE),
            .LAYER_SZ (LAYER_SZ),
            .ADDR_W   (ADDR_W)
        ) u_bank (
            .clk       (clk),
            .reset     (reset),
            .we        (bank_we[b]),
            .wr_idx    (wr_idx[ADDR_W-1:0]),
            .wr_data   (wr_data),
            .rd_values (bank_values[b])
        );
    end

endmodule

// File: tb/tb_neuron_layer_buffer.sv
// Directed bench for neuron_layer_buffer: a pass-through instance and a ReLU
// instance share one stimulus stream.
module tb_neuron_layer_buffer;

    localparam int SIZE     = 16;
    localparam int LAYER_SZ = 84;
    localparam int ADDR_W   = $clog2(LAYER_SZ);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                     in_valid = 1'b0;
    logic [SIZE-1:0]          in_value = '0;
    logic                     flush = 1'b0;
    logic                     consume = 1'b0;

    logic                     in_ready,  in_ready_r;
    logic                     o_valid,   o_valid_r;
    logic [LAYER_SZ*SIZE-1:0] o_values,  o_values_r;
    logic [ADDR_W:0]          o_fill,    o_fill_r;
    logic                     o_err,     o_err_r;

    neuron_layer_buffer #(.SIZE(SIZE), .LAYER_SZ(LAYER_SZ), .RELU(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .flush(flush), .consume(consume),
        .o_valid(o_valid), .o_values(o_values), .o_fill(o_fill), .o_err(o_err)
    );

    neuron_layer_buffer #(.SIZE(SIZE), .LAYER_SZ(LAYER_SZ), .RELU(1)) dut_r (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_r),
        .in_value(in_value), .flush(flush), .consume(consume),
        .o_valid(o_valid_r), .o_values(o_values_r), .o_fill(o_fill_r), .o_err(o_err_r)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SIZE-1:0] elem(input logic [LAYER_SZ*SIZE-1:0] v, input int i);
        return v[i*SIZE +: SIZE];
    endfunction

    // ---------------- driver tasks ----------------
    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Stream n values base..base+n-1 back-to-back; optionally consume on the last one.
    task automatic stream(input int base, input int n, input bit consume_last, input string tag);
        int stalls;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_value = 16'(base + i);
            consume  = consume_last && (i == n - 1);
            if (!in_ready) stalls++;
            tick();
        end
        in_valid = 1'b0;
        consume  = 1'b0;
        check({tag, "_stalls"}, 32'(stalls), 32'd0);
    endtask

    // Compare every element of a bank against base+i.
    task automatic check_ramp(input string tag, input int base);
        int bad;
        bad = 0;
        for (int i = 0; i < LAYER_SZ; i++) begin
            if (elem(o_values, i) !== 16'(base + i)) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #1;
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_o_valid",  32'(o_valid),  32'd0);
        check("rst_o_fill",   32'(o_fill),   32'd0);
        check("rst_o_err",    32'(o_err),    32'd0);
        check("rst_values",   32'(|o_values), 32'd0);

        // Stream 0..83: o_valid rises right after the final accept
        stream(0, LAYER_SZ - 1, 1'b0, "s0");
        check("s0_fill_82", 32'(o_fill), 32'd83);
        in_valid = 1'b1;
        in_value = 16'd83;
        check("s0_valid_pre", 32'(o_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        check("s0_valid_post", 32'(o_valid),  32'd1);
        check("s0_in_ready",   32'(in_ready), 32'd1);
        check("s0_fill",       32'(o_fill),   32'd0);
        check_ramp("s0_ramp", 0);

        // Fill bank 1 with no consume: both full, input stalls
        stream(100, LAYER_SZ, 1'b0, "s1");
        check("both_in_ready", 32'(in_ready), 32'd0);
        check("both_elem5",    32'(elem(o_values, 5)), 32'd5);
        in_valid = 1'b1;
        in_value = 16'd999;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        check("stall_fill",     32'(o_fill),   32'd0);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        consume = 1'b1;
        tick();
        consume = 1'b0;
        check("c1_valid",    32'(o_valid),  32'd1);
        check("c1_in_ready", 32'(in_ready), 32'd1);
        check_ramp("c1_ramp", 100);
        check("c1_err",      32'(o_err),    32'd0);

        // Partial fill of bank 0, flush with a simultaneous offer
        stream(500, 10, 1'b0, "p");
        check("p_fill", 32'(o_fill), 32'd10);
        in_valid = 1'b1;
        in_value = 16'd777;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_fill", 32'(o_fill), 32'd0);

        // Refill bank 0; last write coincides with consume of bank 1
        stream(200, LAYER_SZ, 1'b1, "r0");
        check("r0_valid",    32'(o_valid),  32'd1);
        check("r0_in_ready", 32'(in_ready), 32'd1);
        check("r0_rd_sel",   32'(dut.rd_sel), 32'd0);
        check("r0_wr_sel",   32'(dut.wr_sel), 32'd1);
        check("r0_elem0",    32'(elem(o_values, 0)), 32'd200);
        check_ramp("r0_ramp", 200);

        // Final write of bank 1 together with consume of bank 0
        stream(300, LAYER_SZ, 1'b1, "r1");
        check("r1_valid",    32'(o_valid),  32'd1);
        check("r1_in_ready", 32'(in_ready), 32'd1);
        check("r1_rd_sel",   32'(dut.rd_sel), 32'd1);
        check("r1_wr_sel",   32'(dut.wr_sel), 32'd0);
        check_ramp("r1_ramp", 300);
        check("r1_err",      32'(o_err),    32'd0);

        // ReLU on/off: -5, 7, 0x8000
        do_reset();
        in_valid = 1'b1;
        in_value = 16'hFFFB; tick();
        in_value = 16'h0007; tick();
        in_value = 16'h8000; tick();
        in_valid = 1'b0;
        check("relu_e0", 32'(elem(o_values_r, 0)), 32'h0000);
        check("relu_e1", 32'(elem(o_values_r, 1)), 32'h0007);
        check("relu_e2", 32'(elem(o_values_r, 2)), 32'h0000);
        check("raw_e0",  32'(elem(o_values, 0)),   32'hFFFB);
        check("raw_e2",  32'(elem(o_values, 2)),   32'h8000);

        // Consume with nothing valid: sticky error, no state change
        consume = 1'b1;
        tick();
        consume = 1'b0;
        check("err_set",      32'(o_err),    32'd1);
        check("err_valid",    32'(o_valid),  32'd0);
        check("err_in_ready", 32'(in_ready), 32'd1);
        check("err_fill",     32'(o_fill),   32'd3);
        tick();
        check("err_sticky",   32'(o_err),    32'd1);

        // Reset after 40 writes
        stream(1000, 37, 1'b0, "m");
        check("m_fill", 32'(o_fill), 32'd40);
        do_reset();
        check("mr_fill",     32'(o_fill),    32'd0);
        check("mr_err",      32'(o_err),     32'd0);
        check("mr_valid",    32'(o_valid),   32'd0);
        check("mr_in_ready", 32'(in_ready),  32'd1);
        check("mr_values",   32'(|o_values), 32'd0);
        check("mr_values_r", 32'(|o_values_r), 32'd0);

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
